fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives a separate dual-port memory with a registered read address, and gives it valid/ready streaming ports. The memory's write side is driven from the upstream producer interface. Reads are prefetched from the memory, which has 1-cycle read latency, into a 2-entry output buffer. This hides that latency and sustains one word per cycle at the consumer.

---
 rtl/fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: drives an external dual-port memory with a 1-cycle
// registered read and prefetches into a 2-entry output buffer for full-rate streaming.
module fifo_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               mem_we,
    output logic [DEPTH-1:0]   mem_waddr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [DEPTH-1:0]   mem_raddr,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic [DEPTH+1:0]   level
);

    localparam int unsigned SLOTS = 2 ** DEPTH;
    localparam int unsigned CNT_W = DEPTH + 1;
    localparam int unsigned LVL_W = DEPTH + 2;

    typedef enum logic [1:0] {
        OQ_EMPTY = 2'd0,
        OQ_ONE   = 2'd1,
        OQ_TWO   = 2'd2
    } oq_state_t;

    oq_state_t        oq_state, oq_next;
    logic [WIDTH-1:0] head_q, tail_q, head_d, tail_d;
    logic [DEPTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] mem_cnt;
    logic             rd_pending;
    logic [1:0]       oq_cnt;
    logic             push, pop, issue;

    assign oq_cnt    = 2'(oq_state);
    assign in_ready  = (mem_cnt != CNT_W'(SLOTS));
    assign out_valid = (oq_state != OQ_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Only fetch when a buffer slot is guaranteed free by the time the data returns.
    assign issue = (mem_cnt != '0) &&
                   (({1'b0, oq_cnt} + 3'(rd_pending)) <= (3'(pop) + 3'd1));

    assign mem_we    = push;
    assign mem_waddr = wr_ptr;
    assign mem_wdata = in_data;
    assign mem_raddr = rd_ptr;
    assign out_data  = head_q;
    assign level     = LVL_W'(mem_cnt) + LVL_W'(rd_pending) + LVL_W'(oq_cnt);

    // State, pointer and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            rd_pending <= 1'b0;
            oq_state   <= OQ_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + DEPTH'(1);
            end
            case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
                2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            rd_pending <= issue;
            oq_state   <= oq_next;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Output buffer next state: capture of returning read data and pop from head
    always_comb begin
        oq_next = oq_state;
        head_d  = head_q;
        tail_d  = tail_q;
        case (oq_state)
            OQ_EMPTY: begin
                if (rd_pending) begin
                    head_d  = mem_rdata;
                    oq_next = OQ_ONE;
                end
            end
            OQ_ONE: begin
                if (rd_pending && pop) begin
                    head_d = mem_rdata;
                end else if (rd_pending) begin
                    tail_d  = mem_rdata;
                    oq_next = OQ_TWO;
                end else if (pop) begin
                    oq_next = OQ_EMPTY;
                end
            end
            OQ_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (rd_pending) begin
                        tail_d = mem_rdata;
                    end else begin
                        oq_next = OQ_ONE;
                    end
                end
            end
            default: oq_next = OQ_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomised bench for fifo_ctrl: queue-based reference model checked every cycle,
// plus literal expectations for reset, latency, fill, streaming and mid-stream reset.
module tb_fifo_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int          SLOTS = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               mem_we;
    logic [DEPTH-1:0]   mem_waddr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [DEPTH-1:0]   mem_raddr;
    logic [WIDTH-1:0]   mem_rdata;
    logic [DEPTH+1:0]   level;

    fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .level     (level)
    );

    always #5 clk = ~clk;

    // External memory: write port plus registered read address
    logic [WIDTH-1:0] mem [SLOTS];
    logic [DEPTH-1:0] raddr_q = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        raddr_q <= mem_raddr;
    end
    assign mem_rdata = mem[raddr_q];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one FIFO queue; front ob_n words sit in the output buffer, next fl_n in flight
    logic [31:0] mq[$];
    int ob_n = 0, fl_n = 0, wr_cnt = 0, rd_cnt = 0;
    int pops = 0;
    logic [31:0] got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_memcnt();
        return mq.size() - ob_n - fl_n;
    endfunction

    task automatic model_clear();
        mq.delete();
        ob_n = 0; fl_n = 0; wr_cnt = 0; rd_cnt = 0;
        got.delete();
    endtask

    // One cycle: drive, compare all outputs against model, clock, advance model
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
        logic m_rdy, p, q, is;
        int mc;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        mc    = m_memcnt();
        m_rdy = (mc != SLOTS);
        check("out_valid", 64'(out_valid), 64'(ob_n > 0));
        if (ob_n > 0) check("out_data", 64'(out_data), 64'(mq[0]));
        check("level", 64'(level), 64'(mq.size()));
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("mem_we", 64'(mem_we), 64'(iv && m_rdy));
        if (iv && m_rdy) begin
            check("mem_waddr", 64'(mem_waddr), 64'(wr_cnt % SLOTS));
            check("mem_wdata", 64'(mem_wdata), 64'(d));
        end
        check("mem_raddr", 64'(mem_raddr), 64'(rd_cnt % SLOTS));
        p  = iv && m_rdy;
        q  = (ob_n > 0) && ordy;
        is = (mc > 0) && (ob_n + fl_n - int'(q) <= 1);
        if (q) got.push_back(out_data);
        @(posedge clk);
        if (q) begin
            void'(mq.pop_front());
            pops++;
        end
        ob_n = ob_n - int'(q) + fl_n;
        fl_n = int'(is);
        if (p) mq.push_back(d);
        wr_cnt += int'(p);
        rd_cnt += int'(is);
        @(negedge clk);
    endtask

    task automatic reset_now();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        int acc, pv, pr, cyc, sent;
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        reset_now();
        check("rst_out_data", 64'(out_data), 64'd0);

        // Single word: out_valid rises two edges after the push edge
        step(1'b1, 32'hA5A5_0001, 1'b1);
        check("sw_lvl_e0", 64'(level), 64'd1);
        check("sw_valid_e0", 64'(out_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1);
        check("sw_valid_e1", 64'(out_valid), 64'd0);
        step(1'b0, 32'h0, 1'b1);
        check("sw_valid_e2", 64'(out_valid), 64'd1);
        check("sw_data", 64'(out_data), 64'hA5A5_0001);
        step(1'b0, 32'h0, 1'b1);
        check("sw_lvl_after_pop", 64'(level), 64'd0);

        // Fill with consumer stalled: exactly 18 words fit
        got.delete();
        acc = 0;
        for (int i = 0; i < 22; i++) begin
            if (m_memcnt() != SLOTS) acc++;
            step(1'b1, 32'(acc - ((m_memcnt() != SLOTS) ? 1 : 0)), 1'b0);
        end
        check("fill_accepted", 64'(acc), 64'd18);
        check("fill_level", 64'(level), 64'd18);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, 32'h0, 1'b1);
        check("fill_ready_rise", 64'(in_ready), 64'd1);
        drain(24);
        check("fill_out_count", 64'(got.size()), 64'd18);
        for (int i = 0; i < got.size(); i++) check("fill_order", 64'(got[i]), 64'(i));

        // Streaming: one word per cycle after the fill latency
        got.delete();
        for (int i = 0; i < 100; i++) step(1'b1, 32'(1000 + i), 1'b1);
        check("stream_pops", 64'(got.size()), 64'd97);
        for (int i = 0; i < got.size(); i++) check("stream_order", 64'(got[i]), 64'(1000 + i));
        drain(6);
        check("stream_empty", 64'(level), 64'd0);

        // Random traffic with varying backpressure, many pointer wraps
        pops = 0; sent = 0; cyc = 0; pv = 50; pr = 50;
        while (pops < 1000 && cyc < 30000) begin
            logic iv;
            if (cyc % 150 == 0) begin
                pv = $urandom_range(10, 100);
                pr = $urandom_range(5, 100);
            end
            iv = (sent < 1000) && ($urandom_range(0, 99) < pv);
            if (iv && m_memcnt() != SLOTS) sent++;
            step(iv, $urandom, ($urandom_range(0, 99) < pr));
            cyc++;
        end
        check("rand_done", 64'(pops), 64'd1000);
        check("rand_wrapped", 64'(rd_cnt > 4 * SLOTS), 64'd1);

        // Mid-stream reset with a read in flight
        for (int i = 0; i < 8; i++) step(1'b1, 32'(50 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("mid_level", 64'(level), 64'd7);
        check("mid_in_flight", 64'(fl_n), 64'd1);
        reset_now();
        check("post_rst_level", 64'(level), 64'd0);
        step(1'b1, 32'h0000_1234, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_first", 64'(out_data), 64'h0000_1234);
        check("post_rst_level1", 64'(level), 64'd1);
        drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
